// File: rtl/mapper_mem_sequencer_if.sv
// mapper_mem_sequencer_if
//   Single-beat SDRAM request bus between the mapper memory sequencer and the
//   shared SDRAM port controller.
//   mem_req   : request, held until mem_ack
//   mem_addr  : byte address (AW bits)
//   mem_we    : 1 = write, 0 = read
//   mem_wdata : write data
//   mem_ack   : one-cycle completion pulse; mem_rdata valid in the same cycle
//   mem_rdata : read data
//   master = sequencer side, slave = memory controller side.
interface mapper_mem_sequencer_if #(
  parameter int AW = 22
);
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic          mem_ack;
  logic [7:0]    mem_rdata;

  modport master (
    output mem_req, mem_addr, mem_we, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr, mem_we, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mapper_mem_sequencer.sv
// mapper_mem_sequencer
//   Takes the mapper's translated PRG (CPU) and CHR (PPU) addresses, masks them
//   to the loaded cart size and issues single-beat requests on the shared
//   SDRAM port, one outstanding request at a time.
//   clk, reset            : clock, asynchronous active-high reset
//   prg_* / chr_*         : per-source strobes, address, allow, data in/out,
//                           one-cycle done pulses
//   vram_ce               : CHR access goes to internal VRAM; strobe ignored
//   prg_rom_mask,
//   prg_ram_mask, chr_mask: cart size masks
//   mem                   : SDRAM request bus (master side)
//   overrun               : sticky; a strobe hit a slot that was still pending
module mapper_mem_sequencer #(
  parameter int AW        = 22,
  parameter bit CHR_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] prg_aout,
  input  logic          prg_read,
  input  logic          prg_write,
  input  logic          prg_allow,
  input  logic [7:0]    prg_din,
  output logic [7:0]    prg_dout,
  output logic          prg_done,
  input  logic [AW-1:0] chr_aout,
  input  logic          chr_read,
  input  logic          chr_write,
  input  logic          chr_allow,
  input  logic [7:0]    chr_din,
  input  logic          vram_ce,
  output logic [7:0]    chr_dout,
  output logic          chr_done,
  input  logic [AW-1:0] prg_rom_mask,
  input  logic [12:0]   prg_ram_mask,
  input  logic [AW-1:0] chr_mask,
  mapper_mem_sequencer_if.master mem,
  output logic          overrun
);

  typedef enum logic [1:0] {IDLE, BUSY_PRG, BUSY_CHR} state_t;

  state_t        state;
  logic          cpu_pend, ppu_pend;
  logic [AW-1:0] prg_slot_addr, chr_slot_addr;
  logic          prg_slot_we, chr_slot_we;
  logic [7:0]    prg_slot_data, chr_slot_data;
  logic          prefer_chr;

  // Upper CHR mask bits are not used: CHR masking only spans 128KB.
  logic unused_chr_mask;
  assign unused_chr_mask = ^chr_mask[AW-1:17];

  // Strobe classification
  logic prg_strobe, prg_cap, prg_drop;
  logic chr_strobe, chr_cap, chr_drop;
  logic prg_is_ram;
  logic [AW-1:0] prg_addr_m, chr_addr_m;

  assign prg_strobe = prg_read | prg_write;
  assign prg_cap    = prg_strobe & prg_allow;
  assign prg_drop   = prg_strobe & ~prg_allow;
  assign chr_strobe = (chr_read | chr_write) & ~vram_ce;
  assign chr_cap    = chr_strobe & (~chr_write | chr_allow);
  assign chr_drop   = chr_strobe & chr_write & ~chr_allow;

  assign prg_is_ram = (prg_aout[AW-1:AW-4] == 4'hF);
  assign prg_addr_m = prg_is_ram ? {prg_aout[AW-1:13], prg_aout[12:0] & prg_ram_mask}
                                 : (prg_aout & prg_rom_mask);
  assign chr_addr_m = {chr_aout[AW-1:17], chr_aout[16:0] & chr_mask[16:0]};

  // A strobe captured this cycle is visible to the idle arbiter immediately,
  // so an idle memory sees mem_req the cycle after the strobe.
  logic          prg_pend_e, chr_pend_e;
  logic [AW-1:0] prg_addr_e, chr_addr_e;
  logic          prg_we_e, chr_we_e;
  logic [7:0]    prg_data_e, chr_data_e;

  assign prg_pend_e = cpu_pend | prg_cap;
  assign chr_pend_e = ppu_pend | chr_cap;
  assign prg_addr_e = prg_cap ? prg_addr_m : prg_slot_addr;
  assign chr_addr_e = chr_cap ? chr_addr_m : chr_slot_addr;
  assign prg_we_e   = prg_cap ? prg_write  : prg_slot_we;
  assign chr_we_e   = chr_cap ? chr_write  : chr_slot_we;
  assign prg_data_e = prg_cap ? prg_din    : prg_slot_data;
  assign chr_data_e = chr_cap ? chr_din    : chr_slot_data;

  logic grant_prg, grant_chr;

  // prefer_chr alternates after every grant so a tie never starves a source.
  always_comb begin
    grant_prg = 1'b0;
    grant_chr = 1'b0;
    if (state == IDLE) begin
      if (prg_pend_e && chr_pend_e) begin
        grant_chr = prefer_chr;
        grant_prg = ~prefer_chr;
      end else begin
        grant_chr = chr_pend_e;
        grant_prg = prg_pend_e;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cpu_pend      <= 1'b0;
      ppu_pend      <= 1'b0;
      prg_slot_addr <= '0;
      chr_slot_addr <= '0;
      prg_slot_we   <= 1'b0;
      chr_slot_we   <= 1'b0;
      prg_slot_data <= '0;
      chr_slot_data <= '0;
      prefer_chr    <= CHR_FIRST;
      prg_dout      <= '1;
      chr_dout      <= '1;
      prg_done      <= 1'b0;
      chr_done      <= 1'b0;
      overrun       <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_we    <= 1'b0;
      mem.mem_wdata <= '0;
    end else begin
      // Filtered accesses retire immediately without touching memory.
      prg_done <= prg_drop;
      chr_done <= chr_drop;
      if (prg_drop && !prg_write)
        prg_dout <= '1;

      if (prg_cap) begin
        prg_slot_addr <= prg_addr_m;
        prg_slot_we   <= prg_write;
        prg_slot_data <= prg_din;
        cpu_pend      <= 1'b1;
        if (cpu_pend)
          overrun <= 1'b1;
      end
      if (chr_cap) begin
        chr_slot_addr <= chr_addr_m;
        chr_slot_we   <= chr_write;
        chr_slot_data <= chr_din;
        ppu_pend      <= 1'b1;
        if (ppu_pend)
          overrun <= 1'b1;
      end

      // Clearing the pend flag here overrides a same-cycle capture, since
      // that capture is exactly what is being granted.
      case (state)
        IDLE: begin
          if (grant_chr) begin
            mem.mem_req   <= 1'b1;
            mem.mem_addr  <= chr_addr_e;
            mem.mem_we    <= chr_we_e;
            mem.mem_wdata <= chr_data_e;
            ppu_pend      <= 1'b0;
            prefer_chr    <= 1'b0;
            state         <= BUSY_CHR;
          end else if (grant_prg) begin
            mem.mem_req   <= 1'b1;
            mem.mem_addr  <= prg_addr_e;
            mem.mem_we    <= prg_we_e;
            mem.mem_wdata <= prg_data_e;
            cpu_pend      <= 1'b0;
            prefer_chr    <= 1'b1;
            state         <= BUSY_PRG;
          end
        end
        BUSY_PRG: begin
          if (mem.mem_ack) begin
            mem.mem_req <= 1'b0;
            if (!mem.mem_we)
              prg_dout <= mem.mem_rdata;
            prg_done <= 1'b1;
            state    <= IDLE;
          end
        end
        BUSY_CHR: begin
          if (mem.mem_ack) begin
            mem.mem_req <= 1'b0;
            if (!mem.mem_we)
              chr_dout <= mem.mem_rdata;
            chr_done <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mapper_mem_sequencer.sv
// tb_mapper_mem_sequencer
//   Directed bench for mapper_mem_sequencer. Cycle t is the cycle a strobe is
//   driven; values are observed 1ns after each rising edge.
module tb_mapper_mem_sequencer;
  localparam int AW = 22;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] prg_aout, chr_aout;
  logic          prg_read, prg_write, prg_allow;
  logic          chr_read, chr_write, chr_allow, vram_ce;
  logic [7:0]    prg_din, chr_din, prg_dout, chr_dout;
  logic          prg_done, chr_done, overrun;
  logic [AW-1:0] prg_rom_mask, chr_mask;
  logic [12:0]   prg_ram_mask;

  int checks   = 0;
  int failures = 0;

  mapper_mem_sequencer_if #(.AW(AW)) bus ();

  mapper_mem_sequencer #(.AW(AW), .CHR_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset),
    .prg_aout(prg_aout), .prg_read(prg_read), .prg_write(prg_write),
    .prg_allow(prg_allow), .prg_din(prg_din), .prg_dout(prg_dout),
    .prg_done(prg_done),
    .chr_aout(chr_aout), .chr_read(chr_read), .chr_write(chr_write),
    .chr_allow(chr_allow), .chr_din(chr_din), .vram_ce(vram_ce),
    .chr_dout(chr_dout), .chr_done(chr_done),
    .prg_rom_mask(prg_rom_mask), .prg_ram_mask(prg_ram_mask),
    .chr_mask(chr_mask),
    .mem(bus.master),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    prg_aout = '0; chr_aout = '0;
    prg_read = 0; prg_write = 0; prg_allow = 1;
    chr_read = 0; chr_write = 0; chr_allow = 1; vram_ce = 0;
    prg_din = '0; chr_din = '0;
    prg_rom_mask = 22'h00_FFFF; prg_ram_mask = 13'h07FF; chr_mask = 22'h00_0FFF;
    bus.mem_ack = 0; bus.mem_rdata = '0;
    step(); step();
    check("rst_req", 32'(bus.mem_req), 32'h0);
    check("rst_prg_dout", 32'(prg_dout), 32'hFF);
    check("rst_chr_dout", 32'(chr_dout), 32'hFF);
    check("rst_done", 32'({prg_done, chr_done}), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    reset = 1'b0;
    step();

    // PRG ROM read, ack 3 cycles after req rises
    prg_aout = 22'h01_C123; prg_read = 1;
    step();                                         // t+1
    prg_read = 0;
    check("rom_req", 32'(bus.mem_req), 32'h1);
    check("rom_addr", 32'(bus.mem_addr), 32'h00_C123);
    check("rom_we", 32'(bus.mem_we), 32'h0);
    step(); step();                                 // t+3
    check("rom_req_held", 32'(bus.mem_req), 32'h1);
    step();                                         // t+4
    check("rom_done_early", 32'(prg_done), 32'h0);
    bus.mem_ack = 1; bus.mem_rdata = 8'h5A;
    step();                                         // t+5
    bus.mem_ack = 0;
    check("rom_done", 32'(prg_done), 32'h1);
    check("rom_dout", 32'(prg_dout), 32'h5A);
    check("rom_req_drop", 32'(bus.mem_req), 32'h0);
    step();
    check("rom_done_pulse", 32'(prg_done), 32'h0);

    // PRG RAM write, allowed
    prg_aout = 22'h3C_1FFF; prg_din = 8'hA5; prg_write = 1;
    step();
    prg_write = 0;
    check("ram_req", 32'(bus.mem_req), 32'h1);
    check("ram_we", 32'(bus.mem_we), 32'h1);
    check("ram_addr", 32'(bus.mem_addr), 32'h3C_07FF);
    check("ram_wdata", 32'(bus.mem_wdata), 32'hA5);
    bus.mem_ack = 1; bus.mem_rdata = 8'h00;
    step();
    bus.mem_ack = 0;
    check("ram_done", 32'(prg_done), 32'h1);
    check("ram_dout_kept", 32'(prg_dout), 32'h5A);

    // PRG write and read refused by the mapper
    step();
    prg_allow = 0; prg_write = 1;
    step();
    prg_write = 0;
    check("deny_wr_req", 32'(bus.mem_req), 32'h0);
    check("deny_wr_done", 32'(prg_done), 32'h1);
    check("deny_wr_dout", 32'(prg_dout), 32'h5A);
    prg_read = 1;
    step();
    prg_read = 0;
    check("deny_rd_req", 32'(bus.mem_req), 32'h0);
    check("deny_rd_done", 32'(prg_done), 32'h1);
    check("deny_rd_dout", 32'(prg_dout), 32'hFF);
    step();
    check("deny_done_pulse", 32'(prg_done), 32'h0);
    prg_allow = 1;

    // Simultaneous PRG and CHR reads: CHR first
    prg_aout = 22'h00_2345; chr_aout = 22'h2A_BCDE;
    prg_read = 1; chr_read = 1;
    step();                                         // t+1
    prg_read = 0; chr_read = 0;
    check("tie_chr_req", 32'(bus.mem_req), 32'h1);
    check("tie_chr_addr", 32'(bus.mem_addr), 32'h2A_0CDE);
    bus.mem_ack = 1; bus.mem_rdata = 8'h3C;
    step();                                         // t+2
    bus.mem_ack = 0;
    check("tie_chr_done", 32'(chr_done), 32'h1);
    check("tie_chr_dout", 32'(chr_dout), 32'h3C);
    check("tie_gap_req", 32'(bus.mem_req), 32'h0);
    check("tie_prg_done0", 32'(prg_done), 32'h0);
    step();                                         // t+3
    check("tie_prg_req", 32'(bus.mem_req), 32'h1);
    check("tie_prg_addr", 32'(bus.mem_addr), 32'h00_2345);
    check("tie_chr_once", 32'(chr_done), 32'h0);
    bus.mem_ack = 1; bus.mem_rdata = 8'h77;
    step();
    bus.mem_ack = 0;
    check("tie_prg_done", 32'(prg_done), 32'h1);
    check("tie_prg_dout", 32'(prg_dout), 32'h77);
    check("tie_chr_quiet", 32'(chr_done), 32'h0);
    step();
    check("tie_prg_once", 32'(prg_done), 32'h0);

    // Two PRG reads while CHR holds memory
    chr_aout = 22'h00_0010; chr_read = 1;
    step();
    chr_read = 0;
    check("ovr_chr_addr", 32'(bus.mem_addr), 32'h00_0010);
    prg_aout = 22'h00_1111; prg_read = 1;
    step();
    prg_aout = 22'h00_2222;
    check("ovr_before", 32'(overrun), 32'h0);
    step();
    prg_read = 0;
    check("ovr_set", 32'(overrun), 32'h1);
    bus.mem_ack = 1; bus.mem_rdata = 8'h11;
    step();
    bus.mem_ack = 0;
    check("ovr_chr_done", 32'(chr_done), 32'h1);
    step();
    check("ovr_prg_req", 32'(bus.mem_req), 32'h1);
    check("ovr_prg_addr", 32'(bus.mem_addr), 32'h00_2222);
    bus.mem_ack = 1; bus.mem_rdata = 8'h22;
    step();
    bus.mem_ack = 0;
    check("ovr_prg_dout", 32'(prg_dout), 32'h22);
    step();
    check("ovr_idle_req", 32'(bus.mem_req), 32'h0);
    check("ovr_sticky", 32'(overrun), 32'h1);

    // CHR write refused, CHR read to VRAM ignored
    chr_allow = 0; chr_write = 1; chr_din = 8'h99;
    step();
    chr_write = 0;
    check("chr_deny_req", 32'(bus.mem_req), 32'h0);
    check("chr_deny_done", 32'(chr_done), 32'h1);
    chr_allow = 1; vram_ce = 1; chr_read = 1;
    step();
    chr_read = 0;
    check("vram_req", 32'(bus.mem_req), 32'h0);
    check("vram_done", 32'(chr_done), 32'h0);
    step();
    check("vram_done2", 32'(chr_done), 32'h0);
    check("vram_dout", 32'(chr_dout), 32'h11);
    vram_ce = 0;

    // Reset while BUSY_PRG
    prg_aout = 22'h00_0005; prg_read = 1;
    step();
    prg_read = 0;
    check("rstm_req_pre", 32'(bus.mem_req), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("rstm_req_async", 32'(bus.mem_req), 32'h0);
    check("rstm_prg_dout", 32'(prg_dout), 32'hFF);
    check("rstm_overrun", 32'(overrun), 32'h0);
    step();
    reset = 1'b0;
    bus.mem_ack = 1; bus.mem_rdata = 8'hEE;
    step();
    bus.mem_ack = 0;
    check("rstm_no_done", 32'(prg_done), 32'h0);
    check("rstm_dout_kept", 32'(prg_dout), 32'hFF);
    check("rstm_req_idle", 32'(bus.mem_req), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mapper_mem_sequencer.md
Name: mapper_mem_sequencer

Overview:
- Sits directly downstream of the cart mappers (MMC1 and relatives).
- Consumes the mapper's translated PRG/CHR addresses and allow flags, masks them to the loaded cart size, and issues single-beat requests to the shared SDRAM port.
- Arbitrates between CPU (PRG) and PPU (CHR) with one outstanding request, and returns read data with done strobes.

Parameters:
- AW, 22, memory byte address width (matches mapper prg_aout/chr_aout).
- CHR_FIRST, 1, 1 = PPU wins simultaneous grants, 0 = CPU wins.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- prg_aout  in  AW  mapper PRG address
- prg_read  in  1  CPU read strobe (single-cycle pulse)
- prg_write  in  1  CPU write strobe (single-cycle pulse)
- prg_allow  in  1  mapper allows the PRG access
- prg_din  in  8  CPU write data
- prg_dout  out  8  PRG read data
- prg_done  out  1  one-cycle pulse: PRG access retired
- chr_aout  in  AW  mapper CHR address
- chr_read  in  1  PPU read strobe (pulse)
- chr_write  in  1  PPU write strobe (pulse)
- chr_allow  in  1  mapper allows CHR writes
- chr_din  in  8  PPU write data
- vram_ce  in  1  access routed to internal VRAM; block ignores it
- chr_dout  out  8  CHR read data
- chr_done  out  1  one-cycle pulse: CHR access retired
- prg_rom_mask  in  AW  PRG ROM size mask (size-1)
- prg_ram_mask  in  13  PRG RAM mask within 8KB window
- chr_mask  in  AW  CHR size mask
- mem_req  out  1  SDRAM request, held until ack
- mem_addr  out  AW  SDRAM byte address
- mem_we  out  1  1 = write
- mem_wdata  out  8  write data
- mem_ack  in  1  one-cycle pulse: request complete; rdata valid same cycle
- mem_rdata  in  8  read data
- overrun  out  1  sticky: a strobe arrived while the same source was already pending

Behaviour:
- Reset: all outputs 0 except prg_dout = chr_dout = 8'hFF; pending flags clear; FSM in IDLE.
- Capture, every clk:
  - On a prg_read or prg_write pulse, latch the address, we and data into the PRG slot and set cpu_pend.
  - CHR strobes with vram_ce = 0 do the same into the CHR slot and set ppu_pend.
  - CHR strobes with vram_ce = 1 are ignored; no done pulse.
- Filtering at capture:
  - PRG with prg_allow = 0:
    - Write: discarded; prg_done pulses next cycle; no memory access.
    - Read: prg_dout = 8'hFF; prg_done next cycle; no memory access.
  - CHR write with chr_allow = 0: discarded with chr_done next cycle.
  - CHR reads always proceed.
- Address masking:
  - PRG with prg_aout[AW-1:AW-4] = 4'hF is RAM: mem_addr = {prg_aout[AW-1:13], prg_aout[12:0] & prg_ram_mask}.
  - Otherwise ROM: mem_addr = prg_aout & prg_rom_mask.
  - CHR: mem_addr = {chr_aout[AW-1:17], chr_aout[16:0] & chr_mask[16:0]}.
- FSM states: IDLE, BUSY_PRG, BUSY_CHR.
  - IDLE: if any pending, select per CHR_FIRST when both are pending, otherwise the single one. In the same cycle assert mem_req, drive mem_addr/mem_we/mem_wdata, clear that pending flag, and enter BUSY_x.
  - BUSY_x: hold mem_req and the bus stable until mem_ack.
    - On ack: drop mem_req the next cycle.
    - Read: update x_dout with mem_rdata (registered, visible next cycle).
    - Pulse x_done one cycle after ack.
    - Return to IDLE; a new grant is allowed in the cycle following ack.
- Latency: strobe at cycle t, idle memory, ack arriving k cycles after req rises → done at t+2+k.
- Overlap rules:
  - A strobe for a source whose slot is pending (not yet granted) overwrites the slot and sets overrun.
  - A strobe for a source currently in BUSY is latched into the slot normally (depth-1 queue).
- Simultaneous PRG and CHR capture in one cycle: both latched; arbitration per CHR_FIRST.
- The non-selected source is never starved: after a grant to one source, the other wins the next tie.
- Reset mid-transaction: mem_req drops asynchronously; the in-flight ack after reset is ignored.
- mem_ack while IDLE is ignored.

Test Plan:
- PRG ROM read, prg_aout = 22'h01_C123, prg_rom_mask = 22'h00_FFFF, mem_ack 3 cycles after req with rdata = 8'h5A → mem_addr = 22'h00_C123, prg_dout = 8'h5A, prg_done at t+5.
- PRG RAM write, prg_aout = 22'h3C_1FFF, prg_ram_mask = 13'h07FF, prg_allow = 1 → mem_we = 1, mem_addr = 22'h3C_07FF; with prg_allow = 0 → no mem_req, prg_done at t+1.
- PRG and CHR read strobes in the same cycle, CHR_FIRST = 1 → CHR granted first, PRG granted the cycle after CHR ack; both done pulses seen once each.
- Two PRG reads before the first is granted (memory held busy by CHR) → second address used, overrun = 1 and stays 1 until reset.
- CHR write with chr_allow = 0 → no mem_req, chr_done next cycle; CHR read with vram_ce = 1 → no activity, no done.
- Reset asserted while BUSY_PRG with mem_req = 1 → mem_req = 0 immediately, prg_dout = 8'hFF, a later ack produces no done.
